// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared opcodes, sequencer state encoding and control bundle
//                for the 8-bit accumulator CPU (control unit, ALU, memory).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    // Default width of memory address, program counter and operand field
    localparam int ADDR_W_DEFAULT = 5;

    // Operand bit that selects SHIFT direction: 0 = left, 1 = right
    localparam int SHIFT_DIR_BIT = 4;

    // Opcode map, instruction bits [7:5]
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_NAND  = 3'b010;
    localparam logic [2:0] OP_SHIFT = 3'b011;
    localparam logic [2:0] OP_LD    = 3'b100;
    localparam logic [2:0] OP_ST    = 3'b101;
    localparam logic [2:0] OP_JMP   = 3'b110;
    localparam logic [2:0] OP_JZ    = 3'b111;

    // Sequencer states
    typedef enum logic [1:0] {
        S_FETCH  = 2'b00,
        S_EXEC_A = 2'b01,
        S_EXEC_B = 2'b10
    } state_t;

    // Everything the decoder tells the datapath for the current cycle
    typedef struct packed {
        logic   ld_acc;
        logic   use_alu;
        logic   dbus_sel;
        logic   mem_rd;
        logic   mem_wr;
        logic   addr_from_ir;  // 1: addr = IR operand, 0: addr = pc
        logic   ir_load;       // capture d_in into IR at the edge
        logic   pc_inc;        // pc <- pc + 1 at the edge
        logic   pc_load;       // pc <- IR operand at the edge
        state_t next_state;
    } cu_ctrl_t;

    // SHIFT direction carried by an instruction word (1 = right)
    function automatic logic shift_is_right(input logic [7:0] ir);
        return ir[SHIFT_DIR_BIT];
    endfunction

endpackage

`default_nettype wire

// File: rtl/cu_decode.sv
// ============================================================================
//  Module      : cu_decode
//  Description : Combinational decode of (state, opcode, z) into the strobe
//                set, next state and program-counter update for one cycle.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cu_decode
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] opcode,
    input  logic       z,
    output cu_ctrl_t   ctrl
);

    // Per-state, per-opcode control decode; unknown opcodes fall to all-quiet
    always_comb begin
        ctrl            = '0;
        ctrl.next_state = S_FETCH;
        case (state)
            S_FETCH: begin
                ctrl.mem_rd     = 1'b1;
                ctrl.ir_load    = 1'b1;
                ctrl.pc_inc     = 1'b1;
                ctrl.next_state = S_EXEC_A;
            end
            S_EXEC_A: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_NAND: begin
                        ctrl.addr_from_ir = 1'b1;
                        ctrl.mem_rd       = 1'b1;
                        ctrl.use_alu      = 1'b1;
                    end
                    OP_LD: begin
                        ctrl.addr_from_ir = 1'b1;
                        ctrl.mem_rd       = 1'b1;
                        ctrl.ld_acc       = 1'b1;
                    end
                    OP_SHIFT: begin
                        ctrl.use_alu = 1'b1;
                    end
                    OP_ST: begin
                        // ALU copies acc into its latch ahead of the write
                        ctrl.use_alu    = 1'b1;
                        ctrl.next_state = S_EXEC_B;
                    end
                    OP_JMP: begin
                        ctrl.pc_load = 1'b1;
                    end
                    OP_JZ: begin
                        ctrl.pc_load = (z == 1'b1);
                    end
                    default: begin
                    end
                endcase
            end
            S_EXEC_B: begin
                ctrl.addr_from_ir = 1'b1;
                ctrl.dbus_sel     = 1'b1;
                ctrl.mem_wr       = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
//  Module      : control_unit
//  Description : Instruction sequencer for the 8-bit accumulator CPU. Holds
//                state, program counter and instruction register; outputs are
//                combinational decodes of state and IR.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module control_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        d_in,
    input  logic              z,
    input  logic              c,
    output logic [7:0]        instruction,
    output logic              ldAcc,
    output logic              useAlu,
    output logic              dbusSelect,
    output logic [ADDR_W-1:0] addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] pc
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [ADDR_W-1:0] operand;
    cu_ctrl_t          ctrl;

    // Carry flag is reserved for a future JC opcode
    logic unused_c;
    assign unused_c = c;

    assign operand = ir_q[ADDR_W-1:0];

    cu_decode u_decode (
        .state  (state_q),
        .opcode (ir_q[7:5]),
        .z      (z),
        .ctrl   (ctrl)
    );

    // Next-state values for state, IR and pc
    always_comb begin
        state_d = ctrl.next_state;
        ir_d    = ir_q;
        pc_d    = pc_q;
        if (ctrl.ir_load) begin
            ir_d = d_in;
        end
        if (ctrl.pc_inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end else if (ctrl.pc_load) begin
            pc_d = operand;
        end
    end

    // State, pc and IR registers; reset aborts any instruction immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign instruction = ir_q;
    assign ldAcc       = ctrl.ld_acc;
    assign useAlu      = ctrl.use_alu;
    assign dbusSelect  = ctrl.dbus_sel;
    assign mem_rd      = ctrl.mem_rd;
    assign mem_wr      = ctrl.mem_wr;
    assign addr        = ctrl.addr_from_ir ? operand : pc_q;
    assign pc          = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
//  Module      : tb_control_unit
//  Description : Self-checking bench for control_unit. An instruction-level
//                reference builds the expected per-cycle output trace of each
//                instruction from its word, pc and z.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_control_unit;

    localparam int AW = 5;

    // Observed/expected bundle: instruction, addr, pc, ldAcc, useAlu,
    // dbusSelect, mem_rd, mem_wr
    typedef struct packed {
        logic [7:0]    instr;
        logic [AW-1:0] addr;
        logic [AW-1:0] pc;
        logic          ld;
        logic          ua;
        logic          ds;
        logic          rd;
        logic          wr;
    } obs_t;

    logic          clk;
    logic          reset;
    logic [7:0]    d_in;
    logic          z;
    logic          c;
    logic [7:0]    instruction;
    logic          ldAcc;
    logic          useAlu;
    logic          dbusSelect;
    logic [AW-1:0] addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] pc;

    logic [7:0]    mem [0:31];
    logic          inject_x;
    logic [7:0]    xword;

    logic [AW-1:0] m_pc;
    logic [7:0]    m_ir;
    int            checks;
    int            failures;

    control_unit #(.ADDR_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .d_in        (d_in),
        .z           (z),
        .c           (c),
        .instruction (instruction),
        .ldAcc       (ldAcc),
        .useAlu      (useAlu),
        .dbusSelect  (dbusSelect),
        .addr        (addr),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .pc          (pc)
    );

    // Read-only program memory
    assign d_in = inject_x ? xword : mem[addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input obs_t exp);
        obs_t got;
        got = {instruction, addr, pc, ldAcc, useAlu, dbusSelect, mem_rd, mem_wr};
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed {ir,addr,pc,ld,ua,ds,rd,wr}=%h required=%h",
                   tag, got, exp);
        end
    endtask

    function automatic logic rz();
        return logic'($urandom_range(0, 1));
    endfunction

    // Hold reset for a cycle, checking the reset output values, then release
    task automatic do_reset();
        obs_t e;
        inject_x = 1'b0;
        reset    = 1'b1;
        #1;
        e = {8'h00, 5'd0, 5'd0, 5'b00010};
        check("reset_a", e);
        @(posedge clk);
        #1;
        check("reset_b", e);
        @(negedge clk);
        reset = 1'b0;
        m_pc  = '0;
        m_ir  = 8'h00;
    endtask

    // Run one instruction, comparing every cycle against the trace derived
    // from the instruction word; optionally inject an X word or abort a ST
    task automatic run_instr(input logic zval, input bit xinj, input bit abort,
                             input string tag);
        logic [7:0]    w;
        logic [AW-1:0] opd;
        obs_t          e;
        bit            jump;
        w        = xinj ? xword : mem[m_pc];
        inject_x = xinj;
        z        = zval;
        c        = rz();
        e = {m_ir, m_pc, m_pc, 5'b00010};
        check({tag, " fetch"}, e);
        step();
        inject_x = 1'b0;
        m_ir     = w;
        m_pc     = m_pc + 1'b1;
        opd      = w[AW-1:0];
        jump     = 1'b0;
        e = {w, m_pc, m_pc, 5'b00000};
        case (w[7:5])
            3'b000, 3'b001, 3'b010: begin e.addr = opd; e.rd = 1'b1; e.ua = 1'b1; end
            3'b011:                 begin e.ua = 1'b1; end
            3'b100:                 begin e.addr = opd; e.rd = 1'b1; e.ld = 1'b1; end
            3'b101:                 begin e.ua = 1'b1; end
            3'b110:                 begin jump = 1'b1; end
            3'b111:                 begin jump = (zval === 1'b1); end
            default:                begin end
        endcase
        check({tag, " exec_a"}, e);
        if (xinj) begin
            checks++;
            assert (!$isunknown({ldAcc, useAlu, dbusSelect, mem_rd, mem_wr, addr, pc})) else begin
                failures++;
                $error("FAIL %s x_outputs: observed=%b required no X", tag,
                       {ldAcc, useAlu, dbusSelect, mem_rd, mem_wr, addr, pc});
            end
        end
        step();
        if (w[7:5] === 3'b101) begin
            e = {w, opd, m_pc, 5'b00101};
            check({tag, " exec_b"}, e);
            if (abort) begin
                #3;
                reset = 1'b1;
                #1;
                e = {8'h00, 5'd0, 5'd0, 5'b00010};
                check({tag, " abort"}, e);
                #1;
                reset = 1'b0;
                m_pc  = '0;
                m_ir  = 8'h00;
                return;
            end
            step();
        end
        if (jump) m_pc = opd;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        z        = 1'b0;
        c        = 1'b0;
        inject_x = 1'b0;
        xword    = 8'hxx;
        m_pc     = '0;
        m_ir     = 8'h00;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[0]  = 8'h9E;  // LD 0x1E
        mem[1]  = 8'h05;  // ADD 0x05
        mem[2]  = 8'h26;  // SUB 0x06
        mem[3]  = 8'h47;  // NAND 0x07
        mem[4]  = 8'h60;  // SHIFT left
        mem[5]  = 8'h7F;  // SHIFT right
        mem[6]  = 8'hB0;  // ST 0x10
        mem[7]  = 8'hE3;  // JZ 0x03
        mem[8]  = 8'hDF;  // JMP 0x1F
        mem[31] = 8'hC2;  // JMP 0x02

        // Straight-line program and ST timing
        do_reset();
        for (int i = 0; i < 7; i++) run_instr(rz(), 1'b0, 1'b0, "prog");
        run_instr(1'b1, 1'b0, 1'b0, "jz_taken");
        for (int i = 0; i < 4; i++) run_instr(rz(), 1'b0, 1'b0, "after_jz");
        run_instr(1'b0, 1'b0, 1'b0, "jz_not_taken");
        run_instr(rz(), 1'b0, 1'b0, "jmp_to_31");
        run_instr(rz(), 1'b0, 1'b0, "jmp_at_31");

        // Straight-line code at address 31 wraps pc to 0
        mem[31] = 8'h01;
        for (int i = 0; i < 5; i++) run_instr(rz(), 1'b0, 1'b0, "loop2");
        run_instr(1'b0, 1'b0, 1'b0, "jz_nt2");
        run_instr(rz(), 1'b0, 1'b0, "jmp_to_31b");
        run_instr(rz(), 1'b0, 1'b0, "wrap_at_31");
        run_instr(rz(), 1'b0, 1'b0, "after_wrap");

        // Unknown instruction word fetched
        run_instr(rz(), 1'b1, 1'b0, "x_word");
        run_instr(rz(), 1'b0, 1'b0, "after_x");

        // Asynchronous reset during EXEC_B of a ST, then refetch from 0
        mem[0] = 8'hB0;
        mem[1] = 8'h05;
        do_reset();
        run_instr(rz(), 1'b0, 1'b1, "st_abort");
        for (int i = 0; i < 3; i++) run_instr(rz(), 1'b0, 1'b0, "refetch");

        // Random programs
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        do_reset();
        for (int i = 0; i < 300; i++) run_instr(rz(), 1'b0, 1'b0, "random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
